credit_rr_sched: RTL and testbench



---
 rtl/credit_rr_sched.sv | 105 ++++++++++
 tb/tb_credit_rr_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/credit_rr_sched.sv
// Round-robin scheduler with a registered valid/ready grant stage and an
// up/down credit counter bounding in-flight work to C_CREDITS.
module credit_rr_sched #(
  parameter  int N_REQ     = 4,
  parameter  int C_CREDITS = 16,
  localparam int IDX_W     = $clog2(N_REQ),
  localparam int CRED_W    = $clog2(C_CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_valid_i,
  output logic [N_REQ-1:0]  req_ready_o,
  input  logic              pause_i,
  output logic              grant_valid_o,
  output logic [IDX_W-1:0]  grant_idx_o,
  input  logic              grant_ready_i,
  input  logic              credit_return_i,
  output logic [CRED_W-1:0] credits_o,
  output logic              no_credit_o,
  output logic              idle_o,
  output logic              err_o
);

  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(C_CREDITS);
  localparam logic [IDX_W-1:0]  PTR_INIT  = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0]  r_ptr;
  logic              r_gvalid;
  logic [IDX_W-1:0]  r_gidx;
  logic [CRED_W-1:0] r_credits;
  logic              r_no_credit;
  logic              r_err;

  logic              w_issue_ok;
  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic [IDX_W-1:0]  w_cand;
  logic              w_xfer;
  logic              w_ret_ok;
  logic [CRED_W-1:0] w_cred_next;

  // Eligibility only looks at registered credits, so a return cannot open an issue slot early.
  assign w_issue_ok = rst_n && !pause_i && (r_credits != '0) && (!r_gvalid || grant_ready_i);

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_xfer = w_issue_ok && w_found;

  always_comb begin
    req_ready_o = '0;
    if (w_xfer) req_ready_o[w_win] = 1'b1;
  end

  // Returns at full capacity are dropped; they only raise the sticky error.
  assign w_ret_ok = credit_return_i && (r_credits != CRED_FULL);

  always_comb begin
    w_cred_next = r_credits;
    if (w_xfer && !w_ret_ok)
      w_cred_next = r_credits - 1'b1;
    else if (!w_xfer && w_ret_ok)
      w_cred_next = r_credits + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= PTR_INIT;
      r_gvalid    <= 1'b0;
      r_gidx      <= '0;
      r_credits   <= CRED_FULL;
      r_no_credit <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_credits   <= w_cred_next;
      r_no_credit <= (w_cred_next == '0);
      if (credit_return_i && (r_credits == CRED_FULL)) r_err <= 1'b1;
      if (w_xfer) begin
        r_ptr    <= w_win;
        r_gvalid <= 1'b1;
        r_gidx   <= w_win;
      end else if (grant_ready_i) begin
        r_gvalid <= 1'b0;
      end
    end
  end

  assign grant_valid_o = r_gvalid;
  assign grant_idx_o   = r_gidx;
  assign credits_o     = r_credits;
  assign no_credit_o   = r_no_credit;
  assign idle_o        = (r_credits == CRED_FULL) && !r_gvalid;
  assign err_o         = r_err;

endmodule

// File: tb/tb_credit_rr_sched.sv
// Bench for credit_rr_sched: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_credit_rr_sched;

  localparam int N_REQ     = 4;
  localparam int C_CREDITS = 16;
  localparam int IDX_W     = $clog2(N_REQ);
  localparam int CRED_W    = $clog2(C_CREDITS + 1);

  logic              clk;
  logic              rst_n;
  logic [N_REQ-1:0]  req_valid_i;
  logic [N_REQ-1:0]  req_ready_o;
  logic              pause_i;
  logic              grant_valid_o;
  logic [IDX_W-1:0]  grant_idx_o;
  logic              grant_ready_i;
  logic              credit_return_i;
  logic [CRED_W-1:0] credits_o;
  logic              no_credit_o;
  logic              idle_o;
  logic              err_o;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  int mPtr;
  int mCredits;
  bit mGValid;
  int mGIdx;
  bit mErr;

  credit_rr_sched #(.N_REQ(N_REQ), .C_CREDITS(C_CREDITS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .pause_i         (pause_i),
    .grant_valid_o   (grant_valid_o),
    .grant_idx_o     (grant_idx_o),
    .grant_ready_i   (grant_ready_i),
    .credit_return_i (credit_return_i),
    .credits_o       (credits_o),
    .no_credit_o     (no_credit_o),
    .idle_o          (idle_o),
    .err_o           (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Winner the rules allow this cycle, or -1 when nobody may be accepted.
  function automatic int modelWinner();
    if (!rst_n || pause_i || mCredits == 0 || (mGValid && !grant_ready_i)) return -1;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (mPtr + k) % N_REQ;
      if (req_valid_i[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mPtr = N_REQ - 1; mCredits = C_CREDITS; mGValid = 0; mGIdx = 0; mErr = 0;
    end else begin
      int w;
      int delta;
      w = modelWinner();
      delta = 0;
      if (w >= 0) delta = delta - 1;
      if (credit_return_i) begin
        if (mCredits == C_CREDITS) mErr = 1;
        else delta = delta + 1;
      end
      mCredits = mCredits + delta;
      if (w >= 0) begin
        mPtr = w; mGValid = 1; mGIdx = w;
      end else if (grant_ready_i) begin
        mGValid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      int w;
      logic [31:0] expMask;
      w = modelWinner();
      expMask = (w >= 0) ? (32'd1 << w) : 32'd0;
      checkOutput("model req_ready", 32'(req_ready_o), expMask);
      checkOutput("model grant_valid", 32'(grant_valid_o), 32'(mGValid));
      checkOutput("model grant_idx", 32'(grant_idx_o), mGIdx);
      checkOutput("model credits", 32'(credits_o), mCredits);
      checkOutput("model no_credit", 32'(no_credit_o), 32'(mCredits == 0));
      checkOutput("model idle", 32'(idle_o), 32'(mCredits == C_CREDITS && !mGValid));
      checkOutput("model err", 32'(err_o), 32'(mErr));
    end
  end

  // retMode: 0 drive ret as given, 1 tie to grant acceptance, 2 random but never overflowing.
  task automatic applyStimulus(input logic rst, input logic [N_REQ-1:0] valid, input logic pause,
                               input logic gready, input logic ret, input int retMode);
    @(posedge clk);
    #1;
    rst_n         = rst;
    req_valid_i   = valid;
    pause_i       = pause;
    grant_ready_i = gready;
    case (retMode)
      1:       credit_return_i = grant_valid_o && gready;
      2:       credit_return_i = ($urandom_range(0, 1) == 1) && (mCredits < C_CREDITS);
      default: credit_return_i = ret;
    endcase
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid_i = '0; pause_i = 1'b0; grant_ready_i = 1'b0; credit_return_i = 1'b0;

    applyStimulus(0, 4'b0000, 0, 0, 0, 0);
    checkEn = 1;
    applyStimulus(0, 4'b0000, 0, 0, 0, 0);
    applyStimulus(1, 4'b0000, 0, 0, 0, 0);
    checkOutput("reset credits", 32'(credits_o), 16);
    checkOutput("reset idle", 32'(idle_o), 1);
    checkOutput("reset grant_valid", 32'(grant_valid_o), 0);
    checkOutput("reset no_credit", 32'(no_credit_o), 0);
    checkOutput("reset err", 32'(err_o), 0);

    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 4'b1111, 0, 1, 0, 1);
      checkOutput("rotation ready", 32'(req_ready_o), 32'd1 << (k % 4));
      if (k > 0) begin
        checkOutput("rotation idx", 32'(grant_idx_o), (k - 1) % 4);
        checkOutput("rotation credits", 32'(credits_o), 15);
      end
    end
    applyStimulus(1, 4'b0000, 0, 1, 0, 1);
    applyStimulus(1, 4'b0000, 0, 1, 0, 0);
    checkOutput("drained idle", 32'(idle_o), 1);

    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, 4'b0100, 0, 1, 0, 0);
      checkOutput("exhaust ready", 32'(req_ready_o), 32'b0100);
    end
    applyStimulus(1, 4'b0100, 0, 1, 0, 0);
    checkOutput("exhaust credits", 32'(credits_o), 0);
    checkOutput("exhaust no_credit", 32'(no_credit_o), 1);
    checkOutput("exhaust ready none", 32'(req_ready_o), 0);
    applyStimulus(1, 4'b0100, 0, 1, 1, 0);
    checkOutput("return same-cycle ready", 32'(req_ready_o), 0);
    applyStimulus(1, 4'b0100, 0, 1, 0, 0);
    checkOutput("return credits", 32'(credits_o), 1);
    checkOutput("return ready", 32'(req_ready_o), 32'b0100);
    applyStimulus(1, 4'b0100, 0, 1, 0, 0);
    checkOutput("re-exhaust ready", 32'(req_ready_o), 0);
    for (int k = 0; k < 16; k++) applyStimulus(1, 4'b0000, 0, 1, 1, 0);

    for (int k = 0; k < 13; k++) applyStimulus(1, 4'b0001, 0, 1, 0, 0);
    applyStimulus(1, 4'b0001, 0, 1, 1, 0);
    checkOutput("simul credits before", 32'(credits_o), 3);
    applyStimulus(1, 4'b0010, 0, 1, 0, 0);
    checkOutput("simul credits after", 32'(credits_o), 3);

    applyStimulus(1, 4'b1111, 0, 0, 0, 0);
    checkOutput("bp grant_valid", 32'(grant_valid_o), 1);
    checkOutput("bp idx", 32'(grant_idx_o), 1);
    checkOutput("bp ready", 32'(req_ready_o), 0);
    applyStimulus(1, 4'b1111, 0, 0, 0, 0);
    checkOutput("bp idx hold", 32'(grant_idx_o), 1);
    checkOutput("bp credits hold", 32'(credits_o), 2);
    applyStimulus(1, 4'b1111, 0, 1, 0, 0);
    checkOutput("bp release ready", 32'(req_ready_o), 32'b0100);
    for (int k = 0; k < 15; k++) applyStimulus(1, 4'b0000, 0, 1, 1, 0);
    applyStimulus(1, 4'b0000, 0, 1, 0, 0);
    checkOutput("bp restored credits", 32'(credits_o), 16);

    applyStimulus(1, 4'b0000, 0, 1, 1, 0);
    applyStimulus(1, 4'b0000, 0, 1, 0, 0);
    checkOutput("overflow credits", 32'(credits_o), 16);
    checkOutput("overflow err", 32'(err_o), 1);
    applyStimulus(1, 4'b0000, 0, 1, 0, 0);
    checkOutput("overflow err sticky", 32'(err_o), 1);

    applyStimulus(1, 4'b0001, 0, 1, 0, 0);
    applyStimulus(1, 4'b1111, 1, 0, 1, 0);
    checkOutput("pause ready", 32'(req_ready_o), 0);
    checkOutput("pause idle pending", 32'(idle_o), 0);
    applyStimulus(1, 4'b1111, 1, 1, 0, 0);
    checkOutput("pause ready drain", 32'(req_ready_o), 0);
    applyStimulus(1, 4'b1111, 1, 1, 0, 0);
    checkOutput("pause idle", 32'(idle_o), 1);
    checkOutput("pause ready idle", 32'(req_ready_o), 0);

    for (int k = 0; k < 11; k++) applyStimulus(1, 4'b1111, 0, 1, 0, 0);
    applyStimulus(0, 4'b1111, 0, 1, 0, 0);
    checkOutput("midreset credits before", 32'(credits_o), 5);
    checkOutput("midreset grant before", 32'(grant_valid_o), 1);
    applyStimulus(1, 4'b1111, 0, 1, 0, 0);
    checkOutput("midreset credits", 32'(credits_o), 16);
    checkOutput("midreset grant_valid", 32'(grant_valid_o), 0);
    checkOutput("midreset err", 32'(err_o), 0);
    checkOutput("midreset first ready", 32'(req_ready_o), 32'b0001);
    applyStimulus(1, 4'b0000, 0, 1, 1, 0);
    checkOutput("midreset first idx", 32'(grant_idx_o), 0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 499) != 0), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), 0, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
